// File: rtl/uart_pkg.sv
// Shared constants and types for the UART transmit-side arbitration logic.
// Optional build macro honoured by uart_tx_arbiter: UART_TX_ARB_PRIO_EN.
package uart_pkg;

    localparam int UART_DATA_WIDTH       = 8;
    localparam int DEFAULT_STALL_TIMEOUT = 1024;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches upward from ptr+1 with wrap-around,
// optionally giving requester 0 strict precedence.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               prio_en,
    output logic [IDX_W-1:0]   winner,
    output logic               found
);

    logic [IDX_W-1:0] cand;

    // The first hit wins, so the requester right after ptr has the highest rank.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        if (prio_en && req[0]) begin
            winner = '0;
            found  = 1'b1;
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
                if (!found && req[cand]) begin
                    winner = cand;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter in front of the UART TX FIFO write port, with stall watchdog.
// Define UART_TX_ARB_PRIO_EN to give requester 0 strict priority at each arbitration point.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int  NUM_REQ       = 4,
    parameter int  DATA_WIDTH    = UART_DATA_WIDTH,
    parameter int  STALL_TIMEOUT = DEFAULT_STALL_TIMEOUT,
    localparam int IDX_W         = $clog2(NUM_REQ)
) (
    input  logic                          uart_clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         tx_wr_data,
    output logic                          tx_wr_en,
    input  logic                          tx_full,
    output logic                          busy,
    output logic [IDX_W-1:0]              grant_id,
    output logic                          stall_abort,
    output logic [IDX_W-1:0]              abort_id
);

    localparam int CNT_W = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] grant_id_q, grant_id_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] abort_id_q, abort_id_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [IDX_W-1:0]      arb_winner;
    logic                  arb_found;
    logic                  prio_en;
    logic                  gnt_valid;
    logic                  gnt_last;
    logic [DATA_WIDTH-1:0] gnt_data;
    logic                  xfer;
    logic                  idle_cycle;
    logic                  timeout_hit;

`ifdef UART_TX_ARB_PRIO_EN
    assign prio_en = 1'b1;
`else
    assign prio_en = 1'b0;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (ptr_q),
        .prio_en (prio_en),
        .winner  (arb_winner),
        .found   (arb_found)
    );

    assign gnt_valid  = req_valid[grant_id_q];
    assign gnt_last   = req_last[grant_id_q];
    assign gnt_data   = req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
    assign xfer       = (state_q == GRANT) && gnt_valid && !tx_full;
    // Backpressure from a full FIFO is not the requester's fault, so it never ages the watchdog.
    assign idle_cycle = (state_q == GRANT) && !gnt_valid && !tx_full;

    if (STALL_TIMEOUT > 0) begin : g_watchdog
        assign timeout_hit = idle_cycle && (cnt_q == CNT_W'(STALL_TIMEOUT - 1));
    end else begin : g_no_watchdog
        assign timeout_hit = 1'b0;
    end

    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            ptr_q      <= IDX_W'(NUM_REQ - 1);
            abort_id_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
            abort_id_q <= abort_id_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        abort_id_d = abort_id_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d    = GRANT;
                    grant_id_d = arb_winner;
                    cnt_d      = '0;
                end
            end
            GRANT: begin
                if (xfer) begin
                    cnt_d = '0;
                    if (gnt_last) begin
                        state_d = IDLE;
                        ptr_d   = grant_id_q;
                    end
                end else if (timeout_hit) begin
                    // Bytes already pushed into the FIFO stay there; only the grant is reclaimed.
                    state_d    = IDLE;
                    ptr_d      = grant_id_q;
                    abort_id_d = grant_id_q;
                    cnt_d      = '0;
                end else if (idle_cycle) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready   = '0;
        tx_wr_en    = 1'b0;
        tx_wr_data  = '0;
        busy        = 1'b0;
        stall_abort = 1'b0;
        if (state_q == GRANT) begin
            busy                  = 1'b1;
            req_ready[grant_id_q] = !tx_full;
            tx_wr_en              = xfer;
            tx_wr_data            = gnt_data;
            stall_abort           = timeout_hit;
        end
    end

    assign grant_id = grant_id_q;
    assign abort_id = abort_id_q;

endmodule
